// File: rtl/io_pkg.sv
// Shared types and constants for the processor I/O responder.
// FSM state encoding, seven-segment table (active-low {g..a}) and conversion length.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    CONVERT,
    LOAD,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         CONV_COUNT = 32;

  // Entry n is the pattern for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit <= 4'd9) return SEG_TABLE[digit];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 32-bit binary to 10 BCD digits.
// start loads the operand and performs the first iteration; busy covers the rest.
module bin2bcd_seq
  import io_pkg::*;
(
  input  logic        Clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic [39:0] bcd_out
);

  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [5:0]  r_cnt;

  function automatic logic [71:0] dd_step(input logic [39:0] bcd, input logic [31:0] bin);
    logic [39:0] adj;
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      {r_bcd, r_bin} <= dd_step(40'd0, bin_in);
      r_cnt          <= 6'(CONV_COUNT - 1);
    end else if (r_cnt != 6'd0) begin
      {r_bcd, r_bin} <= dd_step(r_bcd, r_bin);
      r_cnt          <= r_cnt - 6'd1;
    end
  end

  assign busy    = (r_cnt != 6'd0);
  assign bcd_out = r_bcd;

endmodule

// File: rtl/io_responder.sv
// Processor I/O responder: captures switches on a key press, shows values on 8 digits.
// Define IO_DEBOUNCE_EN to debounce the synchronized key over 2^DEBOUNCE_BITS samples.
//
//   state        | meaning
//   IDLE         | waiting for in_req / out_req
//   WAIT_PRESS   | input request, waiting for a fresh key press
//   WAIT_RELEASE | switches captured, waiting for key release
//   CONVERT      | binary-to-BCD conversion running
//   LOAD         | register digits onto HEX, update ovf
//   DONE         | one-cycle completion, requests ignored
module io_responder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        in_req,
  input  logic        out_req,
  input  logic [31:0] out_data,
  input  logic        insert,
  input  logic [14:0] SW,
  output logic [31:0] user_input,
  output logic        stall,
  output logic        done,
  output logic        ovf,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  if (DEBOUNCE_BITS < 1) begin : g_bad_param
    $error("DEBOUNCE_BITS must be at least 1");
  end

  state_t      r_state;
  logic        r_sync1, r_sync2, r_key_prev;
  logic        r_done, r_ovf;
  logic [31:0] r_user_input;
  logic [6:0]  r_hex [8];
  logic        w_key_n, w_press, w_conv_start, w_conv_busy;
  logic [39:0] w_bcd;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= insert;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  logic [DEBOUNCE_BITS-1:0] r_db_cnt;
  logic                     r_key_db;

  // Down-counter reloads whenever the raw key agrees with the accepted level.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_db_cnt <= '1;
      r_key_db <= 1'b1;
    end else if (r_sync2 == r_key_db) begin
      r_db_cnt <= '1;
    end else if (r_db_cnt == '0) begin
      r_key_db <= r_sync2;
      r_db_cnt <= '1;
    end else begin
      r_db_cnt <= r_db_cnt - 1'b1;
    end
  end

  assign w_key_n = r_key_db;
`else
  assign w_key_n = r_sync2;
`endif

  // Edge-based press, so a key already down at request time is not taken.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) r_key_prev <= 1'b1;
    else        r_key_prev <= w_key_n;
  end

  assign w_press      = r_key_prev & ~w_key_n;
  assign w_conv_start = (r_state == IDLE) & out_req;

  bin2bcd_seq u_bin2bcd (
    .Clock   (Clock),
    .reset   (reset),
    .start   (w_conv_start),
    .bin_in  (out_data),
    .busy    (w_conv_busy),
    .bcd_out (w_bcd)
  );

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_user_input <= '0;
      for (int i = 0; i < 8; i++) r_hex[i] <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (out_req)     r_state <= CONVERT;
          else if (in_req) r_state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (w_press) begin
            r_user_input <= {17'b0, SW};
            r_state      <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (w_key_n) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        CONVERT: begin
          if (!w_conv_busy) r_state <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < 8; i++) r_hex[i] <= seg_encode(w_bcd[4*i +: 4]);
          r_ovf   <= (w_bcd[39:32] != 8'd0);
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall = ((r_state == IDLE) & (in_req | out_req)) |
                 (r_state == WAIT_PRESS) | (r_state == WAIT_RELEASE) |
                 (r_state == CONVERT) | (r_state == LOAD);

  assign done       = r_done;
  assign ovf        = r_ovf;
  assign user_input = r_user_input;
  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];
  assign HEX6 = r_hex[6];
  assign HEX7 = r_hex[7];

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder (DEBOUNCE_BITS=4).
// Glitch rejection steps run only when IO_DEBOUNCE_EN is defined.
module tb_io_responder;

  logic        Clock = 1'b0;
  logic        reset;
  logic        in_req, out_req, insert;
  logic [31:0] out_data;
  logic [14:0] SW;
  logic [31:0] user_input;
  logic        stall, done, ovf;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [55:0] hex_all;

  int n_cmp  = 0;
  int n_fail = 0;
  int sc, dc, sd;

  io_responder #(.DEBOUNCE_BITS(4)) dut (
    .Clock(Clock), .reset(reset), .in_req(in_req), .out_req(out_req),
    .out_data(out_data), .insert(insert), .SW(SW), .user_input(user_input),
    .stall(stall), .done(done), .ovf(ovf),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  always #5 Clock = ~Clock;

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; drops requests on the done cycle.
  task automatic wait_done(output int cyc, output int stl);
    cyc = -1;
    stl = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clock);
      if (done && cyc < 0) begin
        cyc     = k;
        stl     = int'(stall);
        in_req  = 1'b0;
        out_req = 1'b0;
        break;
      end
    end
  endtask

  // Issues an output request at a negedge; counts stall cycles and the done cycle.
  task automatic serve_out(input logic [31:0] d, input logic also_in,
                           output int stall_cnt, output int done_cyc, output int stall_done);
    out_data = d;
    out_req  = 1'b1;
    in_req   = also_in;
    #1;
    stall_cnt  = stall ? 1 : 0;
    done_cyc   = -1;
    stall_done = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (done) begin
        done_cyc   = k;
        stall_done = int'(stall);
        out_req    = 1'b0;
        in_req     = 1'b0;
        break;
      end
      if (stall) stall_cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; in_req = 1'b0; out_req = 1'b0; out_data = '0;
    insert = 1'b1; SW = '0;
    repeat (3) @(negedge Clock);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_user_input", user_input, 0);
    chk("rst_hex", hex_all, {8{7'h7F}});
    reset = 1'b1;
    @(negedge Clock);
    chk("idle_stall", stall, 0);

    // 12345678
    serve_out(32'd12345678, 1'b0, sc, dc, sd);
    chk("out1_stall_cycles", sc, 34);
    chk("out1_done_cycle", dc, 34);
    chk("out1_stall_in_done", sd, 0);
    chk("out1_hex", hex_all, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    chk("out1_ovf", ovf, 0);
    @(negedge Clock);
    chk("out1_done_pulse", done, 0);
    chk("out1_idle_stall", stall, 0);

    // 4294967295 -> low 8 digits 94967295, overflow
    serve_out(32'hFFFF_FFFF, 1'b0, sc, dc, sd);
    chk("out2_done_cycle", dc, 34);
    chk("out2_hex", hex_all, {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
    chk("out2_ovf", ovf, 1);

    // data changes in IDLE without a request are ignored
    out_data = 32'd0;
    repeat (5) @(negedge Clock);
    chk("idle_ignore_hex", hex_all, {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
    chk("idle_ignore_stall", stall, 0);

    // input request with press/release
    SW = 15'h5A5A;
    in_req = 1'b1;
    #1;
    chk("in_req_stall", stall, 1);
    repeat (3) @(negedge Clock);
    chk("in_no_press", user_input, 0);
`ifdef IO_DEBOUNCE_EN
    insert = 1'b0;
    repeat (10) @(negedge Clock);
    insert = 1'b1;
    repeat (30) @(negedge Clock);
    chk("glitch_rejected", user_input, 0);
    chk("glitch_stall", stall, 1);
`endif
    insert = 1'b0;
    repeat (20) @(negedge Clock);
    chk("in_capture", user_input, 32'h0000_5A5A);
    chk("in_held_stall", stall, 1);
    chk("in_held_done", done, 0);
    SW = 15'h1234;
    insert = 1'b1;
    wait_done(dc, sd);
    chk("in_done_found", dc > 0, 1);
    chk("in_stall_in_done", sd, 0);
    chk("in_value_held", user_input, 32'h0000_5A5A);
    @(negedge Clock);
    chk("in_done_pulse", done, 0);

    // both requests together: output first, input untouched
    serve_out(32'd42, 1'b1, sc, dc, sd);
    chk("prio_done_cycle", dc, 34);
    chk("prio_hex", hex_all, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
    chk("prio_user_input", user_input, 32'h0000_5A5A);
    chk("prio_ovf", ovf, 0);
    @(negedge Clock);

    // reset at cycle 10 of CONVERT
    out_data = 32'd99999999;
    out_req  = 1'b1;
    repeat (10) @(negedge Clock);
    chk("midconv_stall", stall, 1);
    out_req = 1'b0;
    reset   = 1'b0;
    #1;
    chk("midrst_hex", hex_all, {8{7'h7F}});
    chk("midrst_stall", stall, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_user_input", user_input, 0);
    @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
    serve_out(32'd7, 1'b0, sc, dc, sd);
    chk("post_rst_done_cycle", dc, 34);
    chk("post_rst_hex", hex_all, {{7{7'h40}}, 7'h78});
    @(negedge Clock);

    // key already held at request time is not a press
    insert = 1'b0;
    repeat (30) @(negedge Clock);
    SW = 15'h7FFF;
    in_req = 1'b1;
    repeat (30) @(negedge Clock);
    chk("held_key_ignored", user_input, 0);
    chk("held_key_stall", stall, 1);
    insert = 1'b1;
    repeat (30) @(negedge Clock);
    chk("release_not_press", user_input, 0);
    insert = 1'b0;
    repeat (20) @(negedge Clock);
    chk("fresh_press_capture", user_input, 32'h0000_7FFF);
    insert = 1'b1;
    wait_done(dc, sd);
    chk("fresh_done_found", dc > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter DEBOUNCE_BITS, default 16, which sets the debounce counter width; a press must be stable for 2^DEBOUNCE_BITS cycles.
REQ-002 SHALL have port Clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_req, input, 1, processor input-instruction request, level, held until stall deasserts.
REQ-005 SHALL have port out_req, input, 1, processor output-instruction request, level, held until stall deasserts.
REQ-006 SHALL have port out_data, input, 32, the unsigned value to display, valid with out_req.
REQ-007 SHALL have port insert, input, 1, the user confirm key, active-low, asynchronous to Clock.
REQ-008 SHALL have port SW, input, 15, the user switch value.
REQ-009 SHALL have port user_input, output, 32, the captured switch value, zero-extended.
REQ-010 SHALL have port stall, output, 1, which freezes the processor while high.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port ovf, output, 1, set when the displayed value exceeds 99,999,999.
REQ-013 SHALL have ports HEX0..HEX7, output, 7 each, active-low segments {g..a}; HEX0 is the least-significant digit.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE, CONVERT, LOAD and DONE.
REQ-015 In IDLE, out_req SHALL go to CONVERT (latching out_data), else in_req SHALL go to WAIT_PRESS; out_req has priority when both are high.
REQ-016 stall SHALL be combinational: high when (IDLE and (in_req|out_req)) or state is WAIT_PRESS, WAIT_RELEASE, CONVERT or LOAD; low in DONE.
REQ-017 WAIT_PRESS: on the debounced press edge, user_input SHALL be set to {17'b0,SW} sampled that cycle, and the FSM SHALL go to WAIT_RELEASE.
REQ-018 WAIT_RELEASE: on the debounced release, the FSM SHALL go to DONE; a key already held at request time SHALL NOT be accepted as a press.
REQ-019 CONVERT SHALL run exactly 32 shift-add-3 (double-dabble) iterations, one per cycle, producing 10 BCD digits.
REQ-020 LOAD SHALL register digits 0..7 onto HEX0..HEX7 and set ovf = (digit9|digit8) != 0; the FSM SHALL then go to DONE.
REQ-021 Output latency SHALL be 34 cycles from the IDLE cycle sampling out_req to the DONE cycle.
REQ-022 DONE SHALL assert done for one cycle, ignore requests, and return to IDLE; this ensures a held request is not re-serviced after the processor advances.
REQ-023 In IDLE, out_data changes without a request SHALL be ignored.
REQ-024 Digits 0-9 SHALL use standard segment codes; HEX outputs and user_input SHALL hold their values until the next respective LOAD or capture.
REQ-025 insert SHALL pass through a two-flop synchronizer before any use.

Reset
REQ-026 Asserting reset, including mid-operation, SHALL immediately force IDLE, stall=0 (absent requests), done=0, ovf=0, user_input=0, HEX0..HEX7=7'h7F (blank), and clear the debounce and conversion state.

Configuration
REQ-027 With IO_DEBOUNCE_EN defined, the synchronized key SHALL be accepted only after 2^DEBOUNCE_BITS consecutive equal samples.
REQ-028 Without IO_DEBOUNCE_EN, the synchronized key SHALL be used directly (press latency 2 cycles) and DEBOUNCE_BITS SHALL be unused.

Structure
REQ-029 A shared package io_pkg SHALL hold the FSM state enum, the seven-segment code table constant, the blank constant 7'h7F and the conversion count 32.
REQ-030 The double-dabble converter SHALL be a sub-module bin2bcd_seq (start, busy, 32-bit in, 40-bit BCD out).

Verification
REQ-031 out_req=1, out_data=12345678 -> stall high 34 cycles, done at cycle 34, HEX7..HEX0 show 1,2,3,4,5,6,7,8, ovf=0.
REQ-032 out_data=32'hFFFFFFFF -> HEX shows 94967295, ovf=1.
REQ-033 in_req=1, SW=15'h5A5A, press then release insert -> user_input=32'h00005A5A, done one cycle after release, stall low in DONE.
REQ-034 in_req and out_req high in the same cycle -> output serviced first, user_input unchanged.
REQ-035 reset pulse at cycle 10 of CONVERT -> all HEX=7F, stall=0; a new out_req=7 then shows 00000007.
REQ-036 With IO_DEBOUNCE_EN and DEBOUNCE_BITS=4, a 10-cycle glitch on insert -> no capture; a 20-cycle press -> capture.
